// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module   : ram_arbiter_pkg
// Brief    : Shared constants for the RAM arbiter: FSM encodings, driver
//            enables/ops, reset level, byte-lane mask helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_gap    = 2'd2;
  localparam logic [1:0] c_st_merge  = 2'd3;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RAMWrite_OP = 1'b1;
  localparam logic RAMRead_OP  = 1'b0;
  localparam logic RstEnable   = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic c_master_if  = 1'b0;
  localparam logic c_master_mem = 1'b1;

  // Expand a 4-bit byte select into a 32-bit lane mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_byte_merge.sv
// ============================================================================
// Module   : ram_byte_merge
// Brief    : Combinational byte-lane merge for read-modify-write stores.
//            Present only when RAM_ARB_RMW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef RAM_ARB_RMW_EN
module ram_byte_merge
  import ram_arbiter_pkg::*;
(
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_merged
);

  logic [31:0] w_mask;

  assign w_mask   = byte_mask(i_sel);
  assign o_merged = (i_wdata & w_mask) | (i_rdata & ~w_mask);

endmodule
`endif

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Single master of the RAM driver, arbitrating IF and MEM with an
//            issue/wait/recover sequence. Define RAM_ARB_RMW_EN to turn
//            sub-word stores into read-modify-write pairs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  output logic        if_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_stall_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic        ram_ready_i,
  input  logic [31:0] ram_data_i,
  output logic        busy_o
);

  localparam logic [3:0] c_starve_limit = STARVE_LIMIT[3:0];

  logic [1:0]  r_state;
  logic        r_phase;
  logic [3:0]  r_starve_cnt;
  logic        r_master;
  logic        r_op_we;
  logic        r_rmw;
  logic        r_ram_ce;
  logic        r_ram_we;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_data;
  logic        r_if_ack;
  logic        r_mem_ack;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_data;

  logic w_grant_mem;
  logic w_grant_if;
  logic w_mem_rmw;
  logic w_mem_nop;

`ifdef RAM_ARB_RMW_EN
  logic [3:0]  r_sel;
  logic [31:0] r_rbuf;
  logic [31:0] w_merged;

  assign w_mem_rmw = mem_we_i && (mem_sel_i != 4'hF) && (mem_sel_i != 4'h0);
  assign w_mem_nop = mem_we_i && (mem_sel_i == 4'h0);

  ram_byte_merge u_merge (
    .i_sel    (r_sel),
    .i_wdata  (r_ram_data),
    .i_rdata  (r_rbuf),
    .o_merged (w_merged)
  );
`else
  logic w_unused_sel;

  assign w_unused_sel = ^mem_sel_i;
  assign w_mem_rmw    = 1'b0;
  assign w_mem_nop    = 1'b0;
`endif

  // IF only overtakes a pending MEM once MEM has won STARVE_LIMIT times in a row.
  assign w_grant_mem = mem_req_i && !(if_req_i && (r_starve_cnt == c_starve_limit));
  assign w_grant_if  = if_req_i && !w_grant_mem;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state      <= c_st_idle;
      r_phase      <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_master     <= c_master_if;
      r_op_we      <= RAMRead_OP;
      r_rmw        <= 1'b0;
      r_ram_ce     <= ChipDisable;
      r_ram_we     <= RAMRead_OP;
      r_ram_addr   <= ZeroWord;
      r_ram_data   <= ZeroWord;
      r_if_ack     <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_if_data    <= ZeroWord;
      r_mem_data   <= ZeroWord;
`ifdef RAM_ARB_RMW_EN
      r_sel        <= 4'h0;
      r_rbuf       <= ZeroWord;
`endif
    end else begin
      r_if_ack   <= 1'b0;
      r_mem_ack  <= 1'b0;
      r_if_data  <= ZeroWord;
      r_mem_data <= ZeroWord;
      case (r_state)
        c_st_idle: begin
          if (w_grant_if) begin
            r_master     <= c_master_if;
            r_op_we      <= RAMRead_OP;
            r_rmw        <= 1'b0;
            r_phase      <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_ram_ce     <= ChipEnable;
            r_ram_we     <= RAMRead_OP;
            r_ram_addr   <= if_addr_i;
            r_ram_data   <= ZeroWord;
            r_state      <= c_st_access;
          end else if (w_grant_mem) begin
            r_master   <= c_master_mem;
            r_op_we    <= mem_we_i;
            r_rmw      <= w_mem_rmw;
            r_phase    <= 1'b0;
            r_ram_addr <= mem_addr_i;
            r_ram_data <= mem_data_i;
`ifdef RAM_ARB_RMW_EN
            r_sel      <= mem_sel_i;
`endif
            if (!if_req_i) begin
              r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != c_starve_limit) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (w_mem_nop) begin
              r_mem_ack <= 1'b1;
              r_state   <= c_st_gap;
            end else begin
              r_ram_ce <= ChipEnable;
              r_ram_we <= (mem_we_i && !w_mem_rmw) ? RAMWrite_OP : RAMRead_OP;
              r_state  <= c_st_access;
            end
          end
        end
        c_st_access: begin
          if (ram_ready_i) begin
`ifdef RAM_ARB_RMW_EN
            r_rbuf <= ram_data_i;
`endif
            r_ram_ce <= ChipDisable;
            if (r_rmw && !r_phase) begin
              r_state <= c_st_merge;
            end else begin
              r_state <= c_st_gap;
              if (r_master == c_master_mem) begin
                r_mem_ack  <= 1'b1;
                r_mem_data <= r_op_we ? ZeroWord : ram_data_i;
              end else begin
                r_if_ack  <= 1'b1;
                r_if_data <= ram_data_i;
              end
            end
          end
        end
        c_st_gap: begin
          r_state <= c_st_idle;
        end
        c_st_merge: begin
`ifdef RAM_ARB_RMW_EN
          r_ram_ce   <= ChipEnable;
          r_ram_we   <= RAMWrite_OP;
          r_ram_data <= w_merged;
          r_phase    <= 1'b1;
          r_state    <= c_st_access;
`else
          r_state    <= c_st_idle;
`endif
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign ram_ce_o    = r_ram_ce;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_data_o  = r_ram_data;
  assign if_ack_o    = r_if_ack;
  assign if_data_o   = r_if_data;
  assign mem_ack_o   = r_mem_ack;
  assign mem_data_o  = r_mem_data;
  assign if_stall_o  = if_req_i & ~r_if_ack;
  assign mem_stall_o = mem_req_i & ~r_mem_ack;
  assign busy_o      = (r_state != c_st_idle);

endmodule

`default_nettype wire
